// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle for the multicycle controller: one side drives it, the
// controller consumes it through the central (or slave) view.
interface ctrl_bus_if;
    logic clk;
    logic rst;

    modport master  (output clk, output rst);
    modport slave   (input  clk, input  rst);
    modport central (input  clk, input  rst);
endinterface

// File: rtl/multi_controller.sv
// Main control FSM of the multicycle MIPS core: one instruction step per clock,
// Moore-decoded datapath controls plus a retired-instruction counter.
module multi_controller #(
    parameter int COUNT_W = 32
) (
    ctrl_bus_if.central         ctrl_bus,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                i_or_d,
    output logic                ireg_write_enab,
    output logic                mem_write,
    output logic                alu_srcA,
    output logic [1:0]          alu_srcB,
    output logic [2:0]          alu_ctrl_sig,
    output logic                pc_src,
    output logic                jmp,
    output logic                pc_write_enab,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal,
    output logic [COUNT_W-1:0]  inst_count,
    output logic [3:0]          state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        EXEC      = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11
    } state_t;

    logic clk;
    logic rst;
    assign clk = ctrl_bus.clk;
    assign rst = ctrl_bus.rst;

    state_t             state_reg;
    state_t             state_next;
    logic [COUNT_W-1:0] inst_count_reg;
    logic               funct_ok;
    logic               dispatch_illegal;
    logic               retire;

    logic               ireg_write_raw;
    logic               mem_write_raw;
    logic               pc_write_raw;
    logic               reg_write_raw;

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);
        dispatch_illegal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: dispatch_illegal = 1'b0;
            OP_RTYPE:                            dispatch_illegal = !funct_ok;
            default:                             dispatch_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEM_ADR;
                    OP_RTYPE:     state_next = funct_ok ? EXEC : FETCH;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDI_EXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            // A non-memory op seen here aborts quietly rather than guessing a direction.
            MEM_ADR: begin
                if (op == OP_LW)
                    state_next = MEM_RD;
                else if (op == OP_SW)
                    state_next = MEM_WR;
                else
                    state_next = FETCH;
            end
            MEM_RD:    state_next = MEM_WB;
            EXEC:      state_next = ALU_WB;
            ADDI_EXEC: state_next = ADDI_WB;
            default:   state_next = FETCH;
        endcase
    end

    // Every retiring state is the last step of its instruction.
    assign retire = (state_reg == MEM_WB) || (state_reg == MEM_WR) ||
                    (state_reg == ALU_WB) || (state_reg == BRANCH) ||
                    (state_reg == ADDI_WB) || (state_reg == JUMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= FETCH;
            inst_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                inst_count_reg <= inst_count_reg + COUNT_W'(1);
        end
    end

    always_comb begin
        i_or_d         = 1'b0;
        ireg_write_raw = 1'b0;
        mem_write_raw  = 1'b0;
        alu_srcA       = 1'b0;
        alu_srcB       = 2'b00;
        alu_ctrl_sig   = 3'b000;
        pc_src         = 1'b0;
        jmp            = 1'b0;
        pc_write_raw   = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write_raw  = 1'b0;
        case (state_reg)
            FETCH: begin
                ireg_write_raw = 1'b1;
                alu_srcB       = 2'b01;
                alu_ctrl_sig   = ALU_ADD;
                pc_write_raw   = 1'b1;
            end
            DECODE: begin
                alu_srcB     = 2'b11;
                alu_ctrl_sig = ALU_ADD;
            end
            MEM_ADR: begin
                alu_srcA     = 1'b1;
                alu_srcB     = 2'b10;
                alu_ctrl_sig = ALU_ADD;
            end
            MEM_RD: i_or_d = 1'b1;
            MEM_WB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            MEM_WR: begin
                i_or_d        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXEC: begin
                alu_srcA = 1'b1;
                case (funct)
                    FN_SUB:  alu_ctrl_sig = ALU_SUB;
                    FN_AND:  alu_ctrl_sig = ALU_AND;
                    FN_OR:   alu_ctrl_sig = ALU_OR;
                    FN_SLT:  alu_ctrl_sig = ALU_SLT;
                    default: alu_ctrl_sig = ALU_ADD;
                endcase
            end
            ALU_WB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            // The only Mealy term: the branch is taken when the compare result is zero.
            BRANCH: begin
                alu_srcA     = 1'b1;
                alu_ctrl_sig = ALU_SUB;
                pc_src       = 1'b1;
                pc_write_raw = zero;
            end
            ADDI_EXEC: begin
                alu_srcA     = 1'b1;
                alu_srcB     = 2'b10;
                alu_ctrl_sig = ALU_ADD;
            end
            ADDI_WB: reg_write_raw = 1'b1;
            JUMP: begin
                jmp          = 1'b1;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are held low for the whole reset, not just after the edge.
    assign ireg_write_enab = ireg_write_raw & ~rst;
    assign mem_write       = mem_write_raw  & ~rst;
    assign pc_write_enab   = pc_write_raw   & ~rst;
    assign reg_write       = reg_write_raw  & ~rst;

    assign illegal    = (state_reg == DECODE) && dispatch_illegal && !rst;
    assign inst_count = inst_count_reg;
    assign state_dbg  = state_reg;

endmodule

// File: tb/tb_multi_controller.sv
// Scoreboard bench for multi_controller: expected per-cycle state/controls are
// queued when an instruction is issued and compared as the FSM steps through it.
module tb_multi_controller;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_BAD = 6'b000001;

    ctrl_bus_if bus ();

    logic [5:0]  op, funct;
    logic        zero;
    logic        i_or_d, ireg_write_enab, mem_write, alu_srcA, pc_src, jmp, pc_write_enab;
    logic        reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0]  alu_srcB;
    logic [2:0]  alu_ctrl_sig;
    logic [31:0] inst_count;
    logic [3:0]  state_dbg;

    logic        s_i_or_d, s_ireg, s_mem_write, s_srcA, s_pc_src, s_jmp, s_pc_we;
    logic        s_reg_dst, s_mem_to_reg, s_reg_write, s_illegal;
    logic [1:0]  s_srcB;
    logic [2:0]  s_alu;
    logic [1:0]  s_count;
    logic [3:0]  s_state;

    multi_controller #(.COUNT_W(32)) dut (
        .ctrl_bus(bus), .op(op), .funct(funct), .zero(zero),
        .i_or_d(i_or_d), .ireg_write_enab(ireg_write_enab), .mem_write(mem_write),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl_sig(alu_ctrl_sig),
        .pc_src(pc_src), .jmp(jmp), .pc_write_enab(pc_write_enab), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
        .inst_count(inst_count), .state_dbg(state_dbg)
    );

    // Narrow-counter copy exercises the wrap from all-ones back to zero.
    multi_controller #(.COUNT_W(2)) u_small (
        .ctrl_bus(bus), .op(op), .funct(funct), .zero(zero),
        .i_or_d(s_i_or_d), .ireg_write_enab(s_ireg), .mem_write(s_mem_write),
        .alu_srcA(s_srcA), .alu_srcB(s_srcB), .alu_ctrl_sig(s_alu),
        .pc_src(s_pc_src), .jmp(s_jmp), .pc_write_enab(s_pc_we), .reg_dst(s_reg_dst),
        .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write), .illegal(s_illegal),
        .inst_count(s_count), .state_dbg(s_state)
    );

    logic [15:0] obs_sig, s_sig;
    assign obs_sig = {i_or_d, ireg_write_enab, mem_write, alu_srcA, alu_srcB, alu_ctrl_sig,
                      pc_src, jmp, pc_write_enab, reg_dst, mem_to_reg, reg_write, illegal};
    assign s_sig   = {s_i_or_d, s_ireg, s_mem_write, s_srcA, s_srcB, s_alu,
                      s_pc_src, s_jmp, s_pc_we, s_reg_dst, s_mem_to_reg, s_reg_write, s_illegal};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [15:0] sig;
        logic [31:0] cnt;
        bit          last;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model_cnt;
    int          n_cmp, n_bad;

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(logic iod, logic irw, logic mw, logic sa, logic [1:0] sbs,
                                       logic [2:0] alu, logic ps, logic j, logic pw, logic rd,
                                       logic m2r, logic rw, logic il);
        return {iod, irw, mw, sa, sbs, alu, ps, j, pw, rd, m2r, rw, il};
    endfunction

    function automatic bit funct_legal(logic [5:0] f);
        return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
    endfunction

    function automatic logic [15:0] exp_sig(int s, logic [5:0] f, logic z, logic ill);
        logic [2:0] a;
        case (f)
            FN_ADD: a = 3'b010;
            FN_SUB: a = 3'b110;
            FN_AND: a = 3'b000;
            FN_OR:  a = 3'b001;
            FN_SLT: a = 3'b111;
            default: a = 3'b010;
        endcase
        case (s)
            0:  return mk(0, 1, 0, 0, 2'b01, 3'b010, 0, 0, 1, 0, 0, 0, 0);
            1:  return mk(0, 0, 0, 0, 2'b11, 3'b010, 0, 0, 0, 0, 0, 0, ill);
            2:  return mk(0, 0, 0, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0, 0);
            3:  return mk(1, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
            4:  return mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1, 1, 0);
            5:  return mk(1, 0, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
            6:  return mk(0, 0, 0, 1, 2'b00, a,      0, 0, 0, 0, 0, 0, 0);
            7:  return mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 1, 0);
            8:  return mk(0, 0, 0, 1, 2'b00, 3'b110, 1, 0, z, 0, 0, 0, 0);
            9:  return mk(0, 0, 0, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0, 0);
            10: return mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1, 0);
            11: return mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 1, 0, 0, 0, 0);
            default: return 16'h0;
        endcase
    endfunction

    // Queue the expected cycle-by-cycle behaviour of one instruction.
    task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int  seq[$];
        bit  ill;
        bit  retires;
        ill = 0;
        retires = 1;
        case (o)
            OP_LW:    seq = '{0, 1, 2, 3, 4};
            OP_SW:    seq = '{0, 1, 2, 5};
            OP_RTYPE: if (funct_legal(f)) seq = '{0, 1, 6, 7}; else seq = '{0, 1};
            OP_BEQ:   seq = '{0, 1, 8};
            OP_ADDI:  seq = '{0, 1, 9, 10};
            OP_J:     seq = '{0, 1, 11};
            default:  seq = '{0, 1};
        endcase
        if (seq.size() == 2) begin
            ill = 1;
            retires = 0;
        end
        foreach (seq[i]) begin
            exp_t x;
            x.op = o; x.funct = f; x.zero = z;
            x.st = 4'(seq[i]);
            x.sig = exp_sig(seq[i], f, z, ill && seq[i] == 1);
            x.cnt = model_cnt;
            x.last = (i == seq.size() - 1);
            x.tag = $sformatf("op=%b funct=%b zero=%b", o, f, z);
            sb.push_back(x);
        end
        if (retires) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic test_reset();
        op = OP_LW; funct = FN_ADD; zero = 1'b0;
        bus.rst = 1'b1;
        #1;
        n_cmp++;
        if (state_dbg !== 4'd0 || inst_count !== 32'd0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: state=%0d count=%0d illegal=%b, need 0/0/0",
                     state_dbg, inst_count, illegal);
        end
        repeat (2) @(posedge bus.clk);
        #1;
        n_cmp++;
        if ({reg_write, mem_write, ireg_write_enab, pc_write_enab} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_enables: rw/mw/irw/pcw=%b, need 0000",
                     {reg_write, mem_write, ireg_write_enab, pc_write_enab});
        end
        @(negedge bus.clk);
        bus.rst = 1'b0;
        model_cnt = 32'd0;
        $display("txn reset released");
    endtask

    task automatic test_mem();
        push_instr(OP_LW, FN_ADD, 1'b0);
        push_instr(OP_SW, FN_ADD, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt || s_sig !== e.sig) begin
                n_bad++;
                $display("FAIL mem %s: state=%0d sig=%b cnt=%0d small=%b, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, s_sig, e.st, e.sig, e.cnt);
            end
            if (e.last) $display("txn mem %s done", e.tag);
            @(posedge bus.clk);
            #1;
        end
    endtask

    task automatic test_rtype_addi();
        logic [5:0] fn_list[5];
        fn_list = '{FN_SLT, FN_SUB, FN_ADD, FN_AND, FN_OR};
        foreach (fn_list[i]) push_instr(OP_RTYPE, fn_list[i], 1'b0);
        push_instr(OP_ADDI, FN_BAD, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt || s_count !== e.cnt[1:0]) begin
                n_bad++;
                $display("FAIL rtype_addi %s: state=%0d sig=%b cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, e.st, e.sig, e.cnt);
            end
            if (e.last) $display("txn rtype_addi %s done", e.tag);
            @(posedge bus.clk);
            #1;
        end
    endtask

    task automatic test_branch_jump();
        push_instr(OP_BEQ, FN_ADD, 1'b1);
        push_instr(OP_BEQ, FN_ADD, 1'b0);
        push_instr(OP_J, FN_ADD, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt || s_sig !== e.sig) begin
                n_bad++;
                $display("FAIL branch_jump %s: state=%0d sig=%b cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, e.st, e.sig, e.cnt);
            end
            if (e.last) $display("txn branch_jump %s done", e.tag);
            @(posedge bus.clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        push_instr(OP_BAD, FN_ADD, 1'b0);
        push_instr(OP_RTYPE, FN_BAD, 1'b0);
        push_instr(6'b000001, FN_SLT, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt || s_illegal !== e.sig[0]) begin
                n_bad++;
                $display("FAIL illegal %s: state=%0d sig=%b cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, e.st, e.sig, e.cnt);
            end
            if (e.last) $display("txn illegal %s done", e.tag);
            @(posedge bus.clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_BAD};
        for (int i = 0; i < 30; i++)
            push_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt ||
                s_state !== e.st || s_sig !== e.sig || s_count !== e.cnt[1:0]) begin
                n_bad++;
                $display("FAIL back_to_back %s: state=%0d sig=%b cnt=%0d small_cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, s_count, e.st, e.sig, e.cnt);
            end
            if (e.last) $display("txn back_to_back %s done", e.tag);
            @(posedge bus.clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        push_instr(OP_LW, FN_ADD, 1'b0);
        // Run the LW up to and including its MEM_RD cycle, then hit reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt) begin
                n_bad++;
                $display("FAIL reset_mid_pre %s: state=%0d sig=%b cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, e.st, e.sig, e.cnt);
            end
            if (i < 3) begin
                @(posedge bus.clk);
                #1;
            end
        end
        sb.delete();
        #1;
        bus.rst = 1'b1;
        #1;
        n_cmp++;
        if (state_dbg !== 4'd0 || inst_count !== 32'd0 || s_count !== 2'd0 ||
            {reg_write, mem_write, ireg_write_enab, pc_write_enab} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_async: state=%0d cnt=%0d enables=%b, need 0/0/0000",
                     state_dbg, inst_count, {reg_write, mem_write, ireg_write_enab, pc_write_enab});
        end
        @(posedge bus.clk);
        #1;
        n_cmp++;
        if (state_dbg !== 4'd0 || {reg_write, mem_write, ireg_write_enab, pc_write_enab} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_hold: state=%0d enables=%b, need 0/0000",
                     state_dbg, {reg_write, mem_write, ireg_write_enab, pc_write_enab});
        end
        @(negedge bus.clk);
        bus.rst = 1'b0;
        model_cnt = 32'd0;
        $display("txn reset_mid released");
        push_instr(OP_J, FN_ADD, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (state_dbg !== e.st || obs_sig !== e.sig || inst_count !== e.cnt) begin
                n_bad++;
                $display("FAIL reset_mid_post %s: state=%0d sig=%b cnt=%0d, need state=%0d sig=%b cnt=%0d",
                         e.tag, state_dbg, obs_sig, inst_count, e.st, e.sig, e.cnt);
            end
            @(posedge bus.clk);
            #1;
        end
        n_cmp++;
        if (inst_count !== 32'd1) begin
            n_bad++;
            $display("FAIL reset_mid_count: cnt=%0d, need 1", inst_count);
        end
    endtask

    task automatic test_wrap();
        while (model_cnt[1:0] != 2'd3) push_instr(OP_J, FN_ADD, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            n_cmp++;
            if (s_count !== e.cnt[1:0] || inst_count !== e.cnt) begin
                n_bad++;
                $display("FAIL wrap_pre %s: cnt=%0d small=%0d, need %0d", e.tag, inst_count, s_count, e.cnt);
            end
            @(posedge bus.clk);
            #1;
        end
        n_cmp++;
        if (s_count !== 2'd3) begin
            n_bad++;
            $display("FAIL wrap_at_max: small=%0d, need 3", s_count);
        end
        push_instr(OP_J, FN_ADD, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            @(posedge bus.clk);
            #1;
        end
        n_cmp++;
        if (s_count !== 2'd0 || inst_count !== model_cnt) begin
            n_bad++;
            $display("FAIL wrap_to_zero: small=%0d cnt=%0d, need 0 and %0d", s_count, inst_count, model_cnt);
        end
        $display("txn wrap small counter=%0d wide counter=%0d", s_count, inst_count);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_cnt = 32'd0;
        test_reset();
        test_mem();
        test_rtype_addi();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
